// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use and branch stall/flush, MUL/DIV busy sequencing and stall count.
module hazard_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MulDivStartE,
    input  logic             MulDivDone,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int TW = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lw_stall;
    logic             md_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        lw_stall = ResultSrcE0 && (RdE != 5'd0)
                && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_timeout_d = md_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (MulDivStartE && !MulDivDone) begin
                    state_d = BUSY;
                    cnt_d   = TW'(1);
                end
            end
            BUSY: begin
                if (MulDivDone) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                    if (cnt_q == TO_LAST) begin
                        state_d      = RELEASE;
                        md_timeout_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        md_stall = 1'b0;
        unique case (state_q)
            IDLE:    md_stall = MulDivStartE && !MulDivDone;
            BUSY:    md_stall = !MulDivDone;
            RELEASE: md_stall = 1'b0;
            default: md_stall = 1'b0;
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
            StallF    = lw_stall || md_stall;
            StallD    = lw_stall || md_stall;
            StallE    = md_stall;
            FlushD    = PCSrcE;
            FlushE    = lw_stall || PCSrcE;
            FlushM    = md_stall;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign MdTimeout  = md_timeout_q;
    assign StallCount = stall_cnt_q;

endmodule
